fifo_drain_ctrl: RTL and testbench
==================================

// Module: fifo_drain_ctrl
// PURPOSE
//  Read-side master for the 16x8 synchronous fifo: pops words whenever enabled and data exists,
//  absorbs the fifo's 1-cycle read latency in a 3-entry skid buffer, and presents the data as a
//  valid/ready stream. Counts delivered beats and flags fifo read errors (underflow).
//  Sits between the fifo read port and any downstream consumer.
// PARAMETERS
//  DWIDTH  8   data width; equals fifo word width
//  CNT_W   16  width of delivered-beat counter rd_count_o
// PORTS
//  clk_i          in   1       clock; all logic on rising edge
//  rst_n_i        in   1       reset, asynchronous, active-low
//  en_i           in   1       drain enable (level)
//  clr_i          in   1       sync clear of rd_count_o and err_o
//  fifo_empty_i   in   1       fifo empty flag
//  fifo_rdata_i   in   DWIDTH  fifo read data, valid 1 cycle after fifo_rd_en_o
//  fifo_error_i   in   1       fifo error flag
//  fifo_rd_en_o   out  1       fifo read enable (registered)
//  m_valid_o      out  1       output word valid
//  m_data_o       out  DWIDTH  output word
//  m_ready_i      in   1       consumer accepts word
//  rd_count_o     out  CNT_W   delivered beats, wraps mod 2^CNT_W
//  busy_o         out  1       state != IDLE
//  err_o          out  1       sticky read-error flag
// BEHAVIOUR
//  Reset (rst_n_i=0, async, immediate): fifo_rd_en_o=0, m_valid_o=0, m_data_o=0, rd_count_o=0,
//   busy_o=0, err_o=0, buffer occupancy=0, in-flight=0, state=IDLE. In-flight data is discarded.
//  Read issue: fifo_rd_en_o is registered; it is high in cycle t+1 iff, at edge t,
//   state==ACTIVE && !fifo_empty_i && (occ + inflight) < 3. No path from m_ready_i to fifo_rd_en_o.
//   inflight = fifo_rd_en_o of the previous cycle. Sustains 1 word/cycle when m_ready_i=1.
//  Landing: in the cycle after a read, fifo_rdata_i is pushed into the buffer tail, unless
//   fifo_error_i=1 in that cycle: the word is dropped and err_o is set.
//  Output: m_valid_o = (occ != 0); m_data_o = buffer head. Beat = m_valid_o && m_ready_i.
//   While m_valid_o && !m_ready_i, m_data_o is held stable. Order is strictly FIFO.
//   Push and pop in the same cycle: occ unchanged, order preserved. Buffer never exceeds 3 entries.
//  FSM: IDLE --en_i--> ACTIVE; ACTIVE --!en_i--> STOPPING; STOPPING --en_i--> ACTIVE;
//   STOPPING --(inflight==0 && occ==0)--> IDLE. No reads are issued in IDLE or STOPPING;
//   buffered and in-flight words are still delivered.
//  rd_count_o: +1 per beat, wraps to 0. clr_i=1: rd_count_o<=0 and err_o<=0 next edge.
//   clr_i has priority over a same-cycle beat and a same-cycle error.
//  err_o: sticky; cleared only by clr_i or reset.
//  The fifo deasserts fifo_empty_i/asserts it on the edge of the read that changes it;
//   the controller never issues a read while fifo_empty_i=1.
// TESTING
//  1 fifo holds 0x01..0x10, en_i=1, m_ready_i=1 -> fifo_rd_en_o high 16 consecutive cycles,
//    16 beats 0x01..0x10 in order, one per cycle, rd_count_o=16, err_o=0, busy_o falls after en_i=0.
//  2 Same preload, m_ready_i=0 -> exactly 3 read pulses, m_valid_o=1, m_data_o=0x01 held;
//    then m_ready_i=1 -> remaining 13 fetched, order intact, rd_count_o=16.
//  3 Empty fifo, en_i=1 for 20 cycles -> fifo_rd_en_o never 1, m_valid_o=0, err_o=0.
//  4 Force fifo_error_i=1 in the landing cycle of word 3 -> word dropped, err_o=1 stays set,
//    15 beats delivered; pulse clr_i -> err_o=0, rd_count_o=0.
//  5 en_i dropped after 5 reads -> no further reads, in-flight and buffered words delivered,
//    busy_o=0 once drained. CNT_W=4 with 17 beats -> rd_count_o=1.
//  6 rst_n_i=0 mid-burst, asynchronous to clk_i -> all outputs 0 immediately, before next edge.
//    Restart after release -> clean stream.

Source files
------------

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: read-side master for the 16x8 synchronous fifo.
// Issues registered pops, lands the 1-cycle-late read data in a 3-entry
// skid buffer and presents it downstream as a valid/ready stream. Counts
// delivered beats and keeps a sticky flag for reads the fifo reported as bad.
module fifo_drain_ctrl #(
  parameter int DWIDTH = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              fifo_empty_i,
  input  logic [DWIDTH-1:0] fifo_rdata_i,
  input  logic              fifo_error_i,
  output logic              fifo_rd_en_o,
  output logic              m_valid_o,
  output logic [DWIDTH-1:0] m_data_o,
  input  logic              m_ready_i,
  output logic [CNT_W-1:0]  rd_count_o,
  output logic              busy_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // r_rd_en: read pulse currently on the fifo port.
  // r_land : read pulse of the previous cycle; its data is on fifo_rdata_i now.
  logic              r_rd_en;
  logic              r_land;
  logic [1:0]        r_occ;
  logic [DWIDTH-1:0] r_buf [0:2];
  logic [CNT_W-1:0]  r_count;
  logic              r_err;

  logic              w_beat;
  logic              w_push;
  logic              w_drop;
  logic              w_issue;
  logic              w_busy;
  logic              w_drained;
  logic [2:0]        w_credit;
  logic [1:0]        w_occ_pop;
  logic [1:0]        w_occ_nxt;
  logic [DWIDTH-1:0] w_buf_nxt [0:2];

  // Handshake and landing qualifiers.
  always_comb begin
    w_beat    = (r_occ != 2'd0) && m_ready_i;
    w_push    = r_land && !fifo_error_i;
    w_drop    = r_land && fifo_error_i;
    w_drained = !r_rd_en && !r_land && (r_occ == 2'd0);
    // Words already owed to the buffer: stored ones plus the two reads that
    // can still be outstanding, less the word leaving on this beat. A new
    // read lands two edges from now, so this must stay below the depth.
    w_credit  = {1'b0, r_occ} + {2'b00, r_rd_en} + {2'b00, r_land}
              - {2'b00, w_beat};
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: STOPPING waits until nothing is buffered or in flight.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (en_i) w_state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (!en_i) w_state_nxt = STOPPING;
      end
      STOPPING: begin
        if (en_i)           w_state_nxt = ACTIVE;
        else if (w_drained) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: reads are only requested while ACTIVE and there is room.
  always_comb begin
    w_busy  = (r_state != IDLE);
    w_issue = (r_state == ACTIVE) && !fifo_empty_i && (w_credit < 3'd3);
  end

  // Read-enable pipeline; m_ready_i only reaches the D input, never the port.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd_en <= 1'b0;
      r_land  <= 1'b0;
    end else begin
      r_rd_en <= w_issue;
      r_land  <= r_rd_en;
    end
  end

  // Skid buffer next value: pop shifts toward the head, push writes the tail.
  always_comb begin
    w_buf_nxt[0] = r_buf[0];
    w_buf_nxt[1] = r_buf[1];
    w_buf_nxt[2] = r_buf[2];
    w_occ_pop    = r_occ - {1'b0, w_beat};
    if (w_beat) begin
      w_buf_nxt[0] = r_buf[1];
      w_buf_nxt[1] = r_buf[2];
    end
    if (w_push) begin
      case (w_occ_pop)
        2'd0:    w_buf_nxt[0] = fifo_rdata_i;
        2'd1:    w_buf_nxt[1] = fifo_rdata_i;
        2'd2:    w_buf_nxt[2] = fifo_rdata_i;
        default: ;
      endcase
    end
    w_occ_nxt = w_occ_pop + {1'b0, w_push};
  end

  // Skid buffer storage; cleared on reset so the idle output word is zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_occ    <= 2'd0;
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_buf[2] <= '0;
    end else begin
      r_occ    <= w_occ_nxt;
      r_buf[0] <= w_buf_nxt[0];
      r_buf[1] <= w_buf_nxt[1];
      r_buf[2] <= w_buf_nxt[2];
    end
  end

  // Beat counter and sticky error; clear wins over a same-cycle beat or error.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (clr_i) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_beat) r_count <= r_count + 1'b1;
      if (w_drop) r_err   <= 1'b1;
    end
  end

  assign fifo_rd_en_o = r_rd_en;
  assign m_valid_o    = (r_occ != 2'd0);
  assign m_data_o     = r_buf[0];
  assign rd_count_o   = r_count;
  assign busy_o       = w_busy;
  assign err_o        = r_err;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: a fifo stand-in, directed scenarios and a random
// phase, all checked every cycle against a queue-based model of the stream.
module tb_fifo_drain_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, clr, fifo_empty, fifo_error, ready;
  logic [7:0] fifo_rdata;
  logic       rd_en, mvalid, busy, err;
  logic [7:0] mdata;
  logic [15:0] cnt;
  logic       rd_en4, mvalid4, busy4, err4;
  logic [7:0] mdata4;
  logic [3:0] cnt4;

  fifo_drain_ctrl #(.DWIDTH(8), .CNT_W(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .clr_i(clr),
    .fifo_empty_i(fifo_empty), .fifo_rdata_i(fifo_rdata), .fifo_error_i(fifo_error),
    .fifo_rd_en_o(rd_en), .m_valid_o(mvalid), .m_data_o(mdata), .m_ready_i(ready),
    .rd_count_o(cnt), .busy_o(busy), .err_o(err));

  fifo_drain_ctrl #(.DWIDTH(8), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .clr_i(clr),
    .fifo_empty_i(fifo_empty), .fifo_rdata_i(fifo_rdata), .fifo_error_i(fifo_error),
    .fifo_rd_en_o(rd_en4), .m_valid_o(mvalid4), .m_data_o(mdata4), .m_ready_i(ready),
    .rd_count_o(cnt4), .busy_o(busy4), .err_o(err4));

  int checks = 0;
  int errors = 0;

  // fifo stand-in: a read registered at an edge pops the word at that edge
  // (empty updates there) and the word appears on rdata for the next cycle.
  logic [7:0] fq[$];
  logic [7:0] hold;
  int         reads, beats, cyc, err_on_read, run, maxrun;
  bit         rand_err;
  logic [7:0] got[$];
  int         beat_cyc[$];

  // Reference model: a queue of stored words, the two outstanding read slots,
  // the enable mode (0 idle, 1 draining, 2 winding down), count and error.
  logic [7:0]  mbuf[$];
  bit          m_rd, m_land, m_err;
  int          m_mode;
  int unsigned m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mbuf.delete();
    m_rd = 0; m_land = 0; m_err = 0; m_mode = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit beat, nrd, drained;
    int owed;
    beat    = (mbuf.size() != 0) && ready;
    drained = !m_rd && !m_land && (mbuf.size() == 0);
    owed    = mbuf.size() + int'(m_rd) + int'(m_land) - int'(beat);
    nrd     = (m_mode == 1) && !fifo_empty && (owed < 3);
    if (clr) begin
      m_cnt = 0; m_err = 0;
    end else begin
      if (beat) m_cnt++;
      if (m_land && fifo_error) m_err = 1;
    end
    if (beat) void'(mbuf.pop_front());
    if (m_land && !fifo_error) mbuf.push_back(fifo_rdata);
    case (m_mode)
      0: if (en) m_mode = 1;
      1: if (!en) m_mode = 2;
      default: begin
        if (en) m_mode = 1;
        else if (drained) m_mode = 0;
      end
    endcase
    m_land = m_rd;
    m_rd   = nrd;
  endtask

  task automatic compare();
    chk("rd_en", rd_en, m_rd);
    chk("m_valid", mvalid, mbuf.size() != 0);
    if (mbuf.size() != 0) chk("m_data", mdata, mbuf[0]);
    chk("rd_count", cnt, m_cnt[15:0]);
    chk("rd_count_w4", cnt4, m_cnt[3:0]);
    chk("busy", busy, m_mode != 0);
    chk("err", err, m_err);
  endtask

  task automatic step();
    bit rd_pre, beat_pre, rst_pre;
    logic [7:0] d_pre;
    rd_pre = rd_en; beat_pre = mvalid && ready; d_pre = mdata; rst_pre = rst_n;
    if (rst_pre) model_edge();
    @(posedge clk); #1;
    cyc++;
    if (beat_pre && rst_pre) begin
      got.push_back(d_pre); beat_cyc.push_back(cyc); beats++;
    end
    fifo_error = 1'b0;
    if (rd_pre) begin
      fifo_rdata = hold;
      if (rand_err && $urandom_range(0, 5) == 0) fifo_error = 1'b1;
      if (err_on_read == reads) fifo_error = 1'b1;
    end else begin
      fifo_rdata = 8'($urandom);
    end
    if (rd_en) begin
      checks++;
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL read_while_empty actual=1 required=0 (t=%0t)", $time);
      end else begin
        hold = fq.pop_front();
      end
      reads++; run++;
      if (run > maxrun) maxrun = run;
    end else begin
      run = 0;
    end
    fifo_empty = (fq.size() == 0);
    if (rst_n) compare();
  endtask

  task automatic run_until_beats(input int n, input int budget, input string name);
    int k = 0;
    while (beats < n && k < budget) begin step(); k++; end
    chk(name, beats, n);
  endtask

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) fq.push_back(8'(base + i));
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic start_test();
    en = 0; ready = 1; rand_err = 0; err_on_read = 0;
    clr = 1; step(); clr = 0;
    fq.delete(); fifo_empty = 1;
    got.delete(); beat_cyc.delete();
    reads = 0; beats = 0; run = 0; maxrun = 0;
  endtask

  task automatic check_seq(input string name, input int n, input int first);
    chk({name, "_len"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) chk(name, got[i], first + i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] saved_first;
    int saved_idx, saved_n;
    rst_n = 1; en = 0; clr = 0; ready = 0; fifo_empty = 1; fifo_error = 0;
    fifo_rdata = 0; hold = 0; reads = 0; beats = 0; cyc = 0; run = 0; maxrun = 0;
    err_on_read = 0; rand_err = 0;
    model_reset();
    #2 rst_n = 0;
    #1;
    chk("reset_rd_en", rd_en, 0);
    chk("reset_valid", mvalid, 0);
    chk("reset_data", mdata, 0);
    chk("reset_count", cnt, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err", err, 0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1;

    // Full preload, consumer always ready: one word per cycle.
    start_test();
    load(16, 1); en = 1; ready = 1;
    run_until_beats(16, 80, "t1_beats");
    chk("t1_read_run", maxrun, 16);
    chk("t1_reads", reads, 16);
    check_seq("t1_order", 16, 1);
    if (beat_cyc.size() == 16) chk("t1_beat_span", beat_cyc[15] - beat_cyc[0], 15);
    chk("t1_count", cnt, 16);
    chk("t1_err", err, 0);
    en = 0; repeat (4) step();
    chk("t1_busy_off", busy, 0);

    // Consumer stalled: exactly three reads fill the buffer, head held.
    start_test();
    load(16, 1); en = 1; ready = 0;
    repeat (20) step();
    chk("t2_reads_stalled", reads, 3);
    chk("t2_valid", mvalid, 1);
    chk("t2_head", mdata, 8'h01);
    ready = 1;
    run_until_beats(16, 80, "t2_beats");
    chk("t2_reads", reads, 16);
    check_seq("t2_order", 16, 1);
    chk("t2_count", cnt, 16);
    en = 0; repeat (4) step();

    // Empty fifo: never read.
    start_test();
    en = 1; ready = 1;
    repeat (20) step();
    chk("t3_reads", reads, 0);
    chk("t3_valid", mvalid, 0);
    chk("t3_err", err, 0);
    en = 0; repeat (3) step();
    chk("t3_busy_off", busy, 0);

    // Third word reported bad: dropped, sticky error until clear.
    start_test();
    load(16, 1); err_on_read = 3; en = 1; ready = 1;
    run_until_beats(15, 80, "t4_beats");
    repeat (5) step();
    chk("t4_beats_final", beats, 15);
    chk("t4_err", err, 1);
    chk("t4_count", cnt, 15);
    chk("t4_len", got.size(), 15);
    for (int i = 0; i < 15 && i < got.size(); i++) chk("t4_order", got[i], (i < 2) ? i + 1 : i + 2);
    err_on_read = 0;
    clr = 1; step(); clr = 0;
    chk("t4_err_clr", err, 0);
    chk("t4_count_clr", cnt, 0);
    en = 0; repeat (4) step();

    // Enable dropped mid-burst: five reads total, all delivered, then idle.
    start_test();
    load(16, 1); en = 1; ready = 1;
    for (int k = 0; k < 40 && reads < 4; k++) step();
    en = 0;
    repeat (10) step();
    chk("t5_reads", reads, 5);
    check_seq("t5_order", 5, 1);
    chk("t5_busy_off", busy, 0);
    chk("t5_fifo_left", fq.size(), 11);
    en = 1;
    run_until_beats(16, 80, "t5_beats16");
    load(1, 8'h11);
    run_until_beats(17, 40, "t5_beats17");
    chk("t5_count17", cnt, 17);
    chk("t5_count_w4", cnt4, 1);
    if (got.size() == 17) chk("t5_last", got[16], 8'h11);
    en = 0; repeat (4) step();

    // Asynchronous reset mid-burst, then restart on the remaining words.
    start_test();
    load(16, 1); en = 1; ready = 1;
    repeat (8) step();
    saved_idx = got.size();
    #3 rst_n = 0;
    #1;
    chk("t6_rst_rd_en", rd_en, 0);
    chk("t6_rst_valid", mvalid, 0);
    chk("t6_rst_data", mdata, 0);
    chk("t6_rst_count", cnt, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_err", err, 0);
    model_reset();
    saved_n = fq.size();
    saved_first = (saved_n > 0) ? fq[0] : 8'h00;
    fifo_error = 0;
    repeat (2) begin @(posedge clk); #1; end
    chk("t6_hold_rd_en", rd_en, 0);
    rst_n = 1;
    run_until_beats(saved_idx + saved_n, 80, "t6_beats");
    if (got.size() > saved_idx) chk("t6_first_after", got[saved_idx], saved_first);
    if (got.size() > 0) chk("t6_last", got[got.size() - 1], 8'h10);
    en = 0; repeat (4) step();
    chk("t6_busy_off", busy, 0);

    // Random traffic, producer refills, random errors and clears.
    start_test();
    rand_err = 1; en = 1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) en = ~en;
      ready = ($urandom_range(0, 2) != 0);
      clr   = ($urandom_range(0, 63) == 0);
      if (fq.size() < 16 && $urandom_range(0, 1) == 1) load(1, $urandom_range(0, 255));
      step();
    end
    rand_err = 0; clr = 0; en = 0; ready = 1;
    repeat (10) step();
    chk("rand_busy_off", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
